// File: rtl/pmips_pkg.sv
// Shared definitions for the PMIPS branch predictor.
//   MODE_*   : predictor flavour selected by the MODE parameter
//   SNT..ST  : two-bit direction counter encodings
//   bp_state_t : table controller state
//   ctr_train  : saturating update of a two-bit direction counter
package pmips_pkg;

  localparam int MODE_STATIC = 0;
  localparam int MODE_1BIT   = 1;
  localparam int MODE_2BIT   = 2;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/pmips_bp_entry_ram.sv
// Predictor entry storage: 2**IDX_W words of EW bits.
//   clock          : write clock
//   clr, clr_idx   : initialisation write, zeroes one word (takes priority)
//   we, waddr, wdata : normal synchronous write
//   raddr, rdata   : asynchronous read
// No reset on the array so it can map onto distributed RAM; the owner
// clears it word by word after reset.
module pmips_bp_entry_ram #(
  parameter int IDX_W = 4,
  parameter int EW    = 16
) (
  input  logic             clock,
  input  logic             clr,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [EW-1:0]    wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [EW-1:0]    rdata
);

  logic [EW-1:0]    mem [2**IDX_W];
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [EW-1:0]    wr_data;

  always_comb begin
    wr_en   = we;
    wr_addr = waddr;
    wr_data = wdata;
    if (clr) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
      wr_data = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pmips_branch_predictor.sv
// Fetch-time dynamic branch predictor: direct-mapped tagged table of targets
// and direction counters, looked up combinationally by IF and trained by MEM.
//   clock, reset (async, active-low)
//   lookup_pc -> predict_hit / predict_taken / predict_target (combinational)
//   update_* : resolved branch from MEM, trains the table
//   flush_all : invalidate whole table (re-runs INIT)
//   busy : table initialising, predictions forced not-taken
//   mispredict / recover_pc : registered one-cycle recovery pulse
//   mispredict_count : saturating count of mispredict pulses (reset only)
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | clearing one entry per cycle, idx 0..ENTRIES-1; busy=1
// RUN   | normal lookup/update; flush_all returns to INIT
module pmips_branch_predictor
  import pmips_pkg::*;
#(
  parameter int AW      = 16,
  parameter int ENTRIES = 16,
  parameter int MODE    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] lookup_pc,
  output logic          predict_hit,
  output logic          predict_taken,
  output logic [AW-1:0] predict_target,
  input  logic          update_valid,
  input  logic [AW-1:0] update_pc,
  input  logic          update_taken,
  input  logic [AW-1:0] update_target,
  input  logic          update_pred_taken,
  input  logic [AW-1:0] update_pred_target,
  input  logic          flush_all,
  output logic          busy,
  output logic          mispredict,
  output logic [AW-1:0] recover_pc,
  output logic [15:0]   mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = AW - IDX_W - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [AW-1:0]    target;
    logic [1:0]       ctr;
  } entry_t;

  bp_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             upd_en;
  entry_t           lk_e, up_e, wr_e;
  logic             wr_en;
  logic             up_hit;
  logic             mis_now;

  // Bit 0 of the PC is dropped: instructions are 16-bit aligned.
  wire [IDX_W-1:0] lk_idx = lookup_pc[IDX_W:1];
  wire [TAG_W-1:0] lk_tag = lookup_pc[AW-1:IDX_W+1];
  wire [IDX_W-1:0] up_idx = update_pc[IDX_W:1];
  wire [TAG_W-1:0] up_tag = update_pc[AW-1:IDX_W+1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (flush_all) state_nxt = INIT;
               else if (idx == IDX_LAST) state_nxt = RUN;
      RUN:     if (flush_all) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    upd_en = 1'b0;
    case (state)
      INIT:    busy = 1'b1;
      RUN:     upd_en = update_valid & ~flush_all;  // flush beats a same-cycle update
      default: busy = 1'b1;
    endcase
  end

  // A flush during INIT restarts the walk so the whole table is cleared again.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         idx <= '0;
    else if (flush_all) idx <= '0;
    else if (busy)      idx <= idx + IDX_W'(1);
  end

  // Table is replicated so lookup and update each get a private read port;
  // both copies receive identical writes.
  pmips_bp_entry_ram #(.IDX_W(IDX_W), .EW($bits(entry_t))) u_ram_lk (
    .clock(clock), .clr(busy), .clr_idx(idx),
    .we(wr_en), .waddr(up_idx), .wdata(wr_e),
    .raddr(lk_idx), .rdata(lk_e)
  );

  pmips_bp_entry_ram #(.IDX_W(IDX_W), .EW($bits(entry_t))) u_ram_up (
    .clock(clock), .clr(busy), .clr_idx(idx),
    .we(wr_en), .waddr(up_idx), .wdata(wr_e),
    .raddr(up_idx), .rdata(up_e)
  );

  always_comb begin
    predict_hit   = lk_e.valid & (lk_e.tag == lk_tag) & ~busy;
    predict_taken = 1'b0;
    if (MODE == MODE_2BIT)      predict_taken = predict_hit & lk_e.ctr[1];
    else if (MODE == MODE_1BIT) predict_taken = predict_hit & lk_e.ctr[0];
    predict_target = predict_taken ? lk_e.target : lookup_pc + AW'(2);
  end

  assign up_hit = up_e.valid & (up_e.tag == up_tag);

  always_comb begin
    wr_en = 1'b0;
    wr_e  = up_e;
    if (upd_en && MODE != MODE_STATIC) begin
      if (up_hit) begin
        wr_en    = 1'b1;
        wr_e.ctr = (MODE == MODE_2BIT) ? ctr_train(up_e.ctr, update_taken)
                                       : {1'b0, update_taken};
        if (update_taken) wr_e.target = update_target;
      end else if (update_taken) begin
        wr_en       = 1'b1;
        wr_e.valid  = 1'b1;
        wr_e.tag    = up_tag;
        wr_e.target = update_target;
        wr_e.ctr    = (MODE == MODE_2BIT) ? WT : WNT;
      end
    end
  end

  // Target only matters when the branch was actually taken.
  assign mis_now = update_valid & ~busy &
                   ((update_taken != update_pred_taken) |
                    (update_taken & (update_pred_target != update_target)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mispredict       <= 1'b0;
      recover_pc       <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= mis_now;
      if (mis_now) recover_pc <= update_taken ? update_target : update_pc + AW'(2);
      if (mis_now && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pmips_branch_predictor.sv
module tb_pmips_branch_predictor;

  typedef struct {
    logic [15:0] rpc;
    logic [15:0] cnt;
  } mis_t;

  typedef struct {
    logic        hit;
    logic        taken;
    logic        busy;
    logic [15:0] tgt;
  } lk_t;

  logic        clock;
  logic        reset;
  logic [15:0] lookup_pc;
  logic        update_valid, upd0_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_pred_taken;
  logic [15:0] update_pred_target;
  logic        flush_all;

  logic        predict_hit, predict_taken, busy, mispredict;
  logic [15:0] predict_target, recover_pc, mispredict_count;
  logic        predict_hit0, predict_taken0, busy0, mispredict0;
  logic [15:0] predict_target0, recover_pc0, mispredict_count0;

  logic lk_chk, lk0_chk;
  int   checks, failures;

  mis_t q_mis[$], q0_mis[$];
  lk_t  q_lk[$], q0_lk[$];
  mis_t m;
  lk_t  l;

  pmips_branch_predictor #(.AW(16), .ENTRIES(16), .MODE(2)) dut (
    .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken),
    .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
    .flush_all(flush_all), .busy(busy), .mispredict(mispredict),
    .recover_pc(recover_pc), .mispredict_count(mispredict_count)
  );

  pmips_branch_predictor #(.AW(16), .ENTRIES(16), .MODE(0)) dut0 (
    .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
    .predict_hit(predict_hit0), .predict_taken(predict_taken0),
    .predict_target(predict_target0),
    .update_valid(upd0_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
    .flush_all(flush_all), .busy(busy0), .mispredict(mispredict0),
    .recover_pc(recover_pc0), .mispredict_count(mispredict_count0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: checks lookups on strobe and pops an expectation on every pulse.
  always @(negedge clock) begin
    if (mispredict) begin
      if (q_mis.size() == 0) chk("unexpected_mispredict", 16'd1, 16'd0);
      else begin
        m = q_mis.pop_front();
        chk("recover_pc", recover_pc, m.rpc);
        chk("mispredict_count", mispredict_count, m.cnt);
      end
    end
    if (mispredict0) begin
      if (q0_mis.size() == 0) chk("m0_unexpected_mispredict", 16'd1, 16'd0);
      else begin
        m = q0_mis.pop_front();
        chk("m0_recover_pc", recover_pc0, m.rpc);
        chk("m0_mispredict_count", mispredict_count0, m.cnt);
      end
    end
    if (lk_chk && q_lk.size() != 0) begin
      l = q_lk.pop_front();
      chk("hit", {15'd0, predict_hit}, {15'd0, l.hit});
      chk("taken", {15'd0, predict_taken}, {15'd0, l.taken});
      chk("target", predict_target, l.tgt);
      chk("busy", {15'd0, busy}, {15'd0, l.busy});
    end
    if (lk0_chk && q0_lk.size() != 0) begin
      l = q0_lk.pop_front();
      chk("m0_hit", {15'd0, predict_hit0}, {15'd0, l.hit});
      chk("m0_taken", {15'd0, predict_taken0}, {15'd0, l.taken});
      chk("m0_target", predict_target0, l.tgt);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    update_valid = 1'b0;
    upd0_valid   = 1'b0;
    lk_chk       = 1'b0;
    lk0_chk      = 1'b0;
    flush_all    = 1'b0;
  endtask

  task automatic lk(input logic [15:0] pc, input logic h, input logic t,
                    input logic [15:0] tg, input logic b);
    lookup_pc = pc;
    lk_chk    = 1'b1;
    q_lk.push_back('{hit: h, taken: t, busy: b, tgt: tg});
  endtask

  task automatic lk0(input logic [15:0] pc, input logic h, input logic t,
                     input logic [15:0] tg);
    lookup_pc = pc;
    lk0_chk   = 1'b1;
    q0_lk.push_back('{hit: h, taken: t, busy: 1'b0, tgt: tg});
  endtask

  task automatic upd(input logic to0, input logic [15:0] pc, input logic tk,
                     input logic [15:0] tg, input logic ptk, input logic [15:0] ptg,
                     input logic exp_mis, input logic [15:0] exp_rpc,
                     input logic [15:0] exp_cnt);
    update_pc          = pc;
    update_taken       = tk;
    update_target      = tg;
    update_pred_taken  = ptk;
    update_pred_target = ptg;
    if (to0) begin
      upd0_valid = 1'b1;
      if (exp_mis) q0_mis.push_back('{rpc: exp_rpc, cnt: exp_cnt});
    end else begin
      update_valid = 1'b1;
      if (exp_mis) q_mis.push_back('{rpc: exp_rpc, cnt: exp_cnt});
    end
  endtask

  task automatic busy_walk(input logic [15:0] pc);
    for (int i = 0; i <= 16; i++) begin
      lk(pc, 1'b0, 1'b0, pc + 16'd2, (i < 16));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; lookup_pc = 16'h0040; update_valid = 1'b0; upd0_valid = 1'b0;
    update_pc = '0; update_taken = 1'b0; update_target = '0;
    update_pred_taken = 1'b0; update_pred_target = '0; flush_all = 1'b0;
    lk_chk = 1'b0; lk0_chk = 1'b0;
    #2;
    chk("reset_mispredict", {15'd0, mispredict}, 16'd0);
    chk("reset_recover_pc", recover_pc, 16'd0);
    chk("reset_count", mispredict_count, 16'd0);
    chk("reset_target", predict_target, 16'h0042);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // 16 busy cycles after reset release, then RUN
    busy_walk(16'h0040);

    // allocate on a taken miss
    upd(0, 16'h0040, 1, 16'h0010, 0, 16'h0000, 1, 16'h0010, 16'd1); tick();
    lk(16'h0040, 1, 1, 16'h0010, 0); tick();

    // two not-taken updates: ctr 2->1 (pulse), 1->0 (no pulse)
    upd(0, 16'h0040, 0, 16'h0000, 1, 16'h0010, 1, 16'h0042, 16'd2); tick();
    lk(16'h0040, 1, 0, 16'h0042, 0); tick();
    upd(0, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'd0); tick();
    lk(16'h0040, 1, 0, 16'h0042, 0); tick();

    // same-cycle lookup shows pre-update ctr (0 then 1), ctr=2 visible after
    upd(0, 16'h0040, 1, 16'h0010, 0, 16'h0000, 1, 16'h0010, 16'd3);
    lk(16'h0040, 1, 0, 16'h0042, 0); tick();
    upd(0, 16'h0040, 1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 16'd0);
    lk(16'h0040, 1, 0, 16'h0042, 0); tick();
    lk(16'h0040, 1, 1, 16'h0010, 0); tick();

    // saturate at 3, one not-taken leaves it taken
    upd(0, 16'h0040, 1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 16'd0); tick();
    upd(0, 16'h0040, 1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 16'd0); tick();
    upd(0, 16'h0040, 0, 16'h0000, 1, 16'h0010, 1, 16'h0042, 16'd4); tick();
    lk(16'h0040, 1, 1, 16'h0010, 0); tick();

    // wrong predicted target, then target overwrite on taken hit
    upd(0, 16'h0040, 1, 16'h0010, 1, 16'h0020, 1, 16'h0010, 16'd5); tick();
    upd(0, 16'h0040, 1, 16'h0080, 1, 16'h0010, 1, 16'h0080, 16'd6); tick();
    lk(16'h0040, 1, 1, 16'h0080, 0); tick();

    // aliasing: 0x0060 shares index 0, replaces 0x0040
    upd(0, 16'h0060, 1, 16'h0030, 0, 16'h0000, 1, 16'h0030, 16'd7); tick();
    lk(16'h0040, 0, 0, 16'h0042, 0); tick();
    lk(16'h0060, 1, 1, 16'h0030, 0); tick();
    lk(16'hFFFE, 0, 0, 16'h0000, 0); tick();

    // flush: 16 busy cycles, update during INIT dropped, table cleared
    flush_all = 1'b1; tick();
    for (int i = 0; i <= 16; i++) begin
      lk(16'h0060, 1'b0, 1'b0, 16'h0062, (i < 16));
      if (i == 3) upd(0, 16'h0060, 1, 16'h0030, 0, 16'h0000, 0, 16'h0000, 16'd0);
      tick();
    end
    // count held across flush
    upd(0, 16'h0040, 1, 16'h0010, 0, 16'h0000, 1, 16'h0010, 16'd8); tick();
    lk(16'h0040, 1, 1, 16'h0010, 0); tick();

    // reset at INIT cycle 5 aborts and clears the count
    flush_all = 1'b1; tick();
    repeat (5) tick();
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    busy_walk(16'h0040);
    upd(0, 16'h0040, 1, 16'h0010, 0, 16'h0000, 1, 16'h0010, 16'd1); tick();

    // MODE=0: never taken, no table writes, taken update still mispredicts
    upd(1, 16'h0040, 1, 16'h0010, 0, 16'h0000, 1, 16'h0010, 16'd1);
    lk0(16'h0040, 0, 0, 16'h0042); tick();
    lk0(16'h0040, 0, 0, 16'h0042); tick();
    upd(1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'd0); tick();
    lk0(16'h0040, 0, 0, 16'h0042); tick();

    tick(); tick();
    chk("pending_mispredicts", 16'(q_mis.size() + q0_mis.size()), 16'd0);
    chk("pending_lookups", 16'(q_lk.size() + q0_lk.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmips_branch_predictor.md
# pmips_branch_predictor

Parametrised dynamic branch predictor for the PMIPS pipeline. It replaces resolve-in-MEM-and-flush with a fetch-time prediction. It sits beside the PC register: the IF stage looks up the current PC and the MEM stage reports each branch outcome back. It holds a direct-mapped, tagged table of target addresses and saturating direction counters, and signals mispredictions with a recovery PC.

## Interface
- AW, 16, instruction address width (bits)
- ENTRIES, 16, table depth; power of two, 4..256
- MODE, 2, 0 = static not-taken, 1 = one-bit history, 2 = two-bit saturating counter
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- lookup_pc  in  AW  current PC (IF stage)
- predict_hit  out  1  valid entry with matching tag (combinational)
- predict_taken  out  1  predicted direction (combinational)
- predict_target  out  AW  predicted next PC (combinational)
- update_valid  in  1  a branch resolves this cycle (MEM stage)
- update_pc  in  AW  resolved branch PC
- update_taken  in  1  actual direction
- update_target  in  AW  actual taken target
- update_pred_taken  in  1  prediction carried down the pipe with this branch
- update_pred_target  in  AW  predicted target carried down the pipe
- flush_all  in  1  synchronous table invalidate
- busy  out  1  table initialising; predictions forced not-taken
- mispredict  out  1  registered one-cycle pulse
- recover_pc  out  AW  correct next PC, valid while mispredict=1
- mispredict_count  out  16  saturating mispredict counter

## Operation
- IDX_W = log2(ENTRIES). Index = pc[IDX_W:1]; bit 0 is ignored because instructions are 16-bit aligned. Tag = pc[AW-1:IDX_W+1].
- Entry fields: valid, tag, target[AW], ctr[2].
- FSM states:
  - INIT: a counter walks idx 0..ENTRIES-1, one per cycle, clearing valid and setting ctr=0. After the last index the FSM moves to RUN. busy=1 throughout.
  - RUN: busy=0. flush_all moves the FSM to INIT with idx=0.
- Lookup: hit = valid & tag match & !busy. taken = hit & (MODE2: ctr[1]; MODE1: ctr[0]; MODE0: 0). target = taken ? entry.target : lookup_pc+2, with wrap-around modulo 2^AW.
- Update in RUN when update_valid=1:
  - Hit, MODE2: taken increments ctr, saturating at 3. Not-taken decrements ctr, saturating at 0. Target is overwritten when taken.
  - Hit, MODE1: ctr = {0, taken}.
  - Miss and taken: allocate or replace the entry with tag, target, and ctr=2 (MODE2) or 1 (MODE1).
  - Miss and not-taken: no write.
  - MODE0: no table writes.
- Updates arriving during INIT are dropped and do not affect mispredict.
- Mispredict = update_valid & (taken≠pred_taken | (taken & pred_target≠update_target)). recover_pc = taken ? update_target : update_pc+2.
- mispredict_count increments on each mispredict pulse and holds at 0xFFFF. Only reset clears it; flush_all does not.

## Timing
- Reset values: FSM=INIT, idx=0, busy=1, mispredict=0, recover_pc=0, mispredict_count=0, all entries invalid. predict_hit/predict_taken read 0 and predict_target reads lookup_pc+2.
- busy stays high for exactly ENTRIES cycles after reset deasserts or after the flush_all cycle.
- Lookup latency is 0 cycles (combinational).
- Updates are written at the posedge of the update cycle. mispredict and recover_pc are valid in the following cycle, for one cycle.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents.
- flush_all in the same cycle as update_valid: the flush wins and the update is dropped.
- Reset asserted mid-INIT or mid-RUN aborts immediately to reset values.

## Structure
- Shared package pmips_pkg:
  - MODE_STATIC/MODE_1BIT/MODE_2BIT constants.
  - Counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - FSM state typedef {INIT, RUN}.
- Sub-module pmips_bp_entry_ram: ENTRIES×(1+tag+AW+2) storage with one asynchronous read port and one synchronous write port, plus the INIT clear write path muxed in. Kept separate so it can map to distributed RAM.

## Test plan
All scenarios use AW=16, ENTRIES=16, MODE=2 unless stated.
- Release reset: busy=1 for 16 cycles, then 0. Lookup 0x0040 gives hit=0, taken=0, target=0x0042.
- Update 0x0040 taken, target 0x0010, pred_taken=0: next cycle mispredict=1, recover_pc=0x0010, count=1. Then lookup 0x0040 gives hit=1, taken=1, target=0x0010.
- Two not-taken updates on 0x0040 with pred_taken=1 then 0: the first gives a mispredict pulse with recover_pc=0x0042 and ctr 2→1. The second gives no pulse and ctr=0. Lookup then gives taken=0.
- Aliasing: 0x0040 is allocated. A taken update on 0x0060 (same index 0, different tag) replaces the entry. Lookup 0x0040 then gives hit=0.
- Same-cycle lookup and update on 0x0040 after allocation: the lookup shows the old ctr. The new ctr is visible the next cycle.
- flush_all with count=3: busy=1 for 16 cycles, all lookups miss, count stays 3. Asserting reset at INIT cycle 5 gives count=0 and a fresh 16-cycle INIT. With MODE=0, taken is always 0 and a taken update pulses mispredict.
